// File: rtl/garegga_snd_cmd_tx_if.sv
// Sound-command link bundle: 68k write port and status on one side,
// soundlatch / Z80INT / acknowledge handshake toward the sound CPU on the other.
interface garegga_snd_cmd_tx_if;
    logic       CPU_WE;
    logic       CPU_A0;
    logic [7:0] CPU_DIN;
    logic [7:0] STATUS;
    logic [7:0] SOUNDLATCH;
    logic       Z80INT;
    logic       Z80_ACK;
    logic       BUSY;
    logic       WAIT_68K;

    modport master (
        output CPU_WE, CPU_A0, CPU_DIN, Z80_ACK,
        input  STATUS, SOUNDLATCH, Z80INT, BUSY, WAIT_68K
    );

    modport slave (
        input  CPU_WE, CPU_A0, CPU_DIN, Z80_ACK,
        output STATUS, SOUNDLATCH, Z80INT, BUSY, WAIT_68K
    );
endinterface

// File: rtl/garegga_snd_cmd_tx.sv
// 68k-side sound command transmitter: queues command bytes and hands them one at a
// time to the sound CPU through the latch, an interrupt pulse and its acknowledge.
module garegga_snd_cmd_tx #(
    parameter int DEPTH = 4,
    parameter int INT_W = 16,
    parameter int GAP   = 32,
    parameter int TOW   = 20
) (
    input  logic CLK96,
    input  logic RESET96,
    garegga_snd_cmd_tx_if.slave bus
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam int GAPW = $clog2(GAP + 1);
    localparam int INTW = $clog2(INT_W + 1);
    localparam int CW0  = (TOW > GAPW) ? TOW : GAPW;
    localparam int CW   = (CW0 > INTW) ? CW0 : INTW;

    localparam logic [CW-1:0] INT_LAST = CW'(INT_W);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
    // Last count before the timeout counter would read all ones.
    localparam logic [CW-1:0] TMO_LAST = CW'((64'd1 << TOW) - 64'd2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PULSE,
        S_ACK_WAIT,
        S_GAP
    } state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [CNTW-1:0] count;
    logic [CNTW-1:0] count_next;
    logic [4:0]      count_ext;
    logic [2:0]      count_sat;
    logic [7:0]      latch_q;
    logic            int_q;
    logic            busy_q;
    logic            wait_q;
    logic            ovf_q;
    logic            tmo_q;
    logic            ack_seen;
    logic [CW-1:0]   timer;

    logic cmd_wr;
    logic ctrl_wr;
    logic flush;
    logic full;
    logic empty;
    logic push;
    logic pop;

    assign cmd_wr  = bus.CPU_WE & ~bus.CPU_A0;
    assign ctrl_wr = bus.CPU_WE & bus.CPU_A0;
    assign flush   = ctrl_wr & bus.CPU_DIN[7];
    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    // A full FIFO rejects the push even when LOAD frees a slot this cycle.
    assign push    = cmd_wr & ~flush & ~full;
    assign pop     = (state == S_LOAD) & ~empty & ~flush;

    assign count_next = flush ? '0 : count + CNTW'(push) - CNTW'(pop);
    assign count_ext  = 5'(count);
    assign count_sat  = (count_ext > 5'd7) ? 3'd7 : count_ext[2:0];

    assign bus.STATUS     = {full, empty, busy_q, ovf_q, tmo_q, count_sat};
    assign bus.SOUNDLATCH = latch_q;
    assign bus.Z80INT     = int_q;
    assign bus.BUSY       = busy_q;
    assign bus.WAIT_68K   = wait_q;

    always_ff @(posedge CLK96) begin
        if (push) begin
            mem[wr_ptr] <= bus.CPU_DIN;
        end
    end

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            wait_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            count  <= count_next;
            wait_q <= (count_next == CNTW'(DEPTH));
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTRW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTRW'(1);
                end
            end
            if (ctrl_wr && bus.CPU_DIN[0]) begin
                ovf_q <= 1'b0;
            end
            if (cmd_wr && !flush && full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // One timer is shared by the pulse, acknowledge-timeout and gap phases.
    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            state    <= S_IDLE;
            latch_q  <= 8'h00;
            int_q    <= 1'b0;
            busy_q   <= 1'b0;
            tmo_q    <= 1'b0;
            ack_seen <= 1'b0;
            timer    <= '0;
        end else begin
            if (ctrl_wr && bus.CPU_DIN[1]) begin
                tmo_q <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        state  <= S_LOAD;
                        busy_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // A flush between the IDLE decision and here leaves nothing to send.
                    if (empty) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        latch_q  <= mem[rd_ptr];
                        state    <= S_PULSE;
                        timer    <= '0;
                        ack_seen <= 1'b0;
                    end
                end
                S_PULSE: begin
                    if (timer == INT_LAST) begin
                        int_q <= 1'b0;
                        timer <= '0;
                        state <= (ack_seen || bus.Z80_ACK) ? S_GAP : S_ACK_WAIT;
                    end else begin
                        int_q <= 1'b1;
                        timer <= timer + CW'(1);
                        if (bus.Z80_ACK) begin
                            ack_seen <= 1'b1;
                        end
                    end
                end
                S_ACK_WAIT: begin
                    if (bus.Z80_ACK) begin
                        state <= S_GAP;
                        timer <= '0;
                    end else if (timer == TMO_LAST) begin
                        tmo_q <= 1'b1;
                        state <= S_GAP;
                        timer <= '0;
                    end else begin
                        timer <= timer + CW'(1);
                    end
                end
                S_GAP: begin
                    if (timer == GAP_LAST) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        timer  <= '0;
                    end else begin
                        timer <= timer + CW'(1);
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    int_q  <= 1'b0;
                    timer  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_garegga_snd_cmd_tx.sv
// Bench for garegga_snd_cmd_tx: directed scenarios plus random traffic, all outputs
// compared every cycle against a timestamp-based model of the link.
module tb_garegga_snd_cmd_tx;
    localparam int DEPTH = 4;
    localparam int INT_W = 16;
    localparam int GAP   = 32;
    localparam int TOW   = 6;
    localparam int TOUT  = (1 << TOW) - 1;

    logic CLK96   = 1'b0;
    logic RESET96 = 1'b1;

    garegga_snd_cmd_tx_if bus ();

    garegga_snd_cmd_tx #(
        .DEPTH(DEPTH),
        .INT_W(INT_W),
        .GAP  (GAP),
        .TOW  (TOW)
    ) dut (
        .CLK96  (CLK96),
        .RESET96(RESET96),
        .bus    (bus)
    );

    always #5 CLK96 = ~CLK96;

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: FIFO as a queue, link timing as edge-index timestamps.
    int         cyc;
    logic [7:0] mq[$];
    logic [7:0] mLatch;
    bit         mOvf;
    bit         mTmo;
    bit         linkIdle;
    bit         earlyAck;
    int         tLoad;
    int         tEnd;
    int         tGapEnd;

    task automatic modelReset();
        mq.delete();
        mLatch   = 8'h00;
        mOvf     = 1'b0;
        mTmo     = 1'b0;
        linkIdle = 1'b1;
        earlyAck = 1'b0;
        tLoad    = -100;
        tEnd     = -100;
        tGapEnd  = -1;
        cyc      = 0;
    endtask

    task automatic modelEdge();
        bit cmdWr;
        bit ctrlWr;
        bit doFlush;
        bit doPop;
        int pre;
        cyc++;
        cmdWr   = bus.CPU_WE && !bus.CPU_A0;
        ctrlWr  = bus.CPU_WE && bus.CPU_A0;
        doFlush = ctrlWr && bus.CPU_DIN[7];
        doPop   = 1'b0;
        pre     = mq.size();
        if (ctrlWr && bus.CPU_DIN[1]) mTmo = 1'b0;
        if (ctrlWr && bus.CPU_DIN[0]) mOvf = 1'b0;

        if (linkIdle) begin
            if (pre != 0) begin
                linkIdle = 1'b0;
                tLoad    = cyc + 1;
                tGapEnd  = -1;
            end
        end else if (cyc == tLoad) begin
            if (pre == 0) begin
                linkIdle = 1'b1;
            end else begin
                mLatch   = mq[0];
                doPop    = !doFlush;
                earlyAck = 1'b0;
                tEnd     = tLoad + INT_W + 1;
            end
        end else if (tGapEnd < 0) begin
            if (cyc <= tEnd) begin
                if (bus.Z80_ACK) earlyAck = 1'b1;
                if (cyc == tEnd && earlyAck) tGapEnd = cyc + GAP;
            end else if (bus.Z80_ACK) begin
                tGapEnd = cyc + GAP;
            end else if (cyc == tEnd + TOUT) begin
                mTmo    = 1'b1;
                tGapEnd = cyc + GAP;
            end
        end else if (cyc == tGapEnd) begin
            linkIdle = 1'b1;
        end

        if (doFlush) begin
            mq.delete();
        end else begin
            if (doPop) void'(mq.pop_front());
            if (cmdWr) begin
                if (pre < DEPTH) mq.push_back(bus.CPU_DIN);
                else mOvf = 1'b1;
            end
        end
    endtask

    function automatic logic [7:0] expStatus();
        int n;
        n = mq.size();
        return {n == DEPTH, n == 0, !linkIdle, mOvf, mTmo, (n > 7) ? 3'd7 : 3'(n)};
    endfunction

    function automatic logic expInt();
        return !linkIdle && (cyc >= tLoad + 1) && (cyc <= tLoad + INT_W);
    endfunction

    initial begin
        modelReset();
        forever begin
            @(posedge CLK96 or posedge RESET96);
            if (RESET96) modelReset();
            else modelEdge();
        end
    end

    initial begin
        forever begin
            @(negedge CLK96);
            if (!RESET96) begin
                checkOutput("cyc.status", bus.STATUS, expStatus());
                checkOutput("cyc.latch", bus.SOUNDLATCH, mLatch);
                checkOutput("cyc.int", bus.Z80INT, expInt());
                checkOutput("cyc.busy", bus.BUSY, !linkIdle);
                checkOutput("cyc.wait", bus.WAIT_68K, mq.size() == DEPTH);
            end
        end
    end

    logic [7:0] got[$];
    int         width;

    task automatic tick();
        @(posedge CLK96);
        #1;
    endtask

    task automatic cpuWrite(input logic a0, input logic [7:0] d);
        bus.CPU_WE  = 1'b1;
        bus.CPU_A0  = a0;
        bus.CPU_DIN = d;
        tick();
        bus.CPU_WE  = 1'b0;
        bus.CPU_A0  = 1'b0;
    endtask

    task automatic sendAck();
        bus.Z80_ACK = 1'b1;
        tick();
        bus.Z80_ACK = 1'b0;
    endtask

    // Counts cycles of Z80INT high; optionally strobes an ACK on pulse cycle ackAt.
    task automatic measurePulse(input int ackAt, output int w);
        w = 0;
        while (bus.Z80INT && w < 100) begin
            w++;
            bus.Z80_ACK = (w == ackAt);
            tick();
        end
        bus.Z80_ACK = 1'b0;
    endtask

    // Holds ACK high until the link is idle and the FIFO empty, logging each latched byte.
    task automatic drainLink();
        int   guard;
        logic prevInt;
        guard       = 0;
        prevInt     = 1'b0;
        bus.Z80_ACK = 1'b1;
        while (!(bus.BUSY == 1'b0 && bus.STATUS[6]) && guard < 3000) begin
            if (bus.Z80INT && !prevInt) got.push_back(bus.SOUNDLATCH);
            prevInt = bus.Z80INT;
            tick();
            guard++;
        end
        bus.Z80_ACK = 1'b0;
        checkOutput("drain.done", guard < 3000, 1);
    endtask

    task automatic applyStimulus(input int cycles);
        int r;
        for (int i = 0; i < cycles; i++) begin
            r = $urandom_range(99);
            bus.CPU_WE = 1'b0;
            bus.CPU_A0 = 1'b0;
            if (r < 30) begin
                bus.CPU_WE  = 1'b1;
                bus.CPU_DIN = 8'($urandom);
            end else if (r < 33) begin
                bus.CPU_WE  = 1'b1;
                bus.CPU_A0  = 1'b1;
                bus.CPU_DIN = {($urandom_range(9) == 0), 5'd0, 2'($urandom)};
            end
            bus.Z80_ACK = ($urandom_range(99) < 4);
            tick();
        end
        bus.CPU_WE  = 1'b0;
        bus.CPU_A0  = 1'b0;
        bus.Z80_ACK = 1'b0;
    endtask

    initial begin
        bus.CPU_WE  = 1'b0;
        bus.CPU_A0  = 1'b0;
        bus.CPU_DIN = 8'h00;
        bus.Z80_ACK = 1'b0;
        repeat (3) tick();
        RESET96 = 1'b0;
        tick();
        checkOutput("rst.status", bus.STATUS, 8'h40);
        checkOutput("rst.latch", bus.SOUNDLATCH, 8'h00);
        checkOutput("rst.int", bus.Z80INT, 1'b0);
        checkOutput("rst.busy", bus.BUSY, 1'b0);
        checkOutput("rst.wait", bus.WAIT_68K, 1'b0);

        // Single command, late acknowledge
        cpuWrite(1'b0, 8'h5A);
        checkOutput("single.count", bus.STATUS, 8'h01);
        tick();
        checkOutput("single.latch_e1", bus.SOUNDLATCH, 8'h00);
        tick();
        checkOutput("single.latch_e2", bus.SOUNDLATCH, 8'h5A);
        checkOutput("single.int_e2", bus.Z80INT, 1'b0);
        tick();
        checkOutput("single.int_e3", bus.Z80INT, 1'b1);
        measurePulse(0, width);
        checkOutput("single.int_width", width, INT_W);
        repeat (9) tick();
        sendAck();
        repeat (31) tick();
        checkOutput("single.gap_busy", bus.BUSY, 1'b1);
        tick();
        checkOutput("single.idle_busy", bus.BUSY, 1'b0);
        checkOutput("single.idle_status", bus.STATUS, 8'h40);

        // Early acknowledge during the pulse
        cpuWrite(1'b0, 8'h77);
        repeat (2) tick();
        checkOutput("early.latch", bus.SOUNDLATCH, 8'h77);
        tick();
        measurePulse(5, width);
        checkOutput("early.int_width", width, INT_W);
        repeat (31) tick();
        checkOutput("early.gap_busy", bus.BUSY, 1'b1);
        tick();
        checkOutput("early.idle_status", bus.STATUS, 8'h40);

        // Timeout with a second byte queued
        cpuWrite(1'b0, 8'h11);
        cpuWrite(1'b0, 8'h22);
        repeat (18) tick();
        checkOutput("tmo.pulse_end", bus.Z80INT, 1'b0);
        checkOutput("tmo.wait_status", bus.STATUS, 8'h21);
        repeat (62) tick();
        checkOutput("tmo.before", bus.STATUS, 8'h21);
        tick();
        checkOutput("tmo.set", bus.STATUS, 8'h29);
        repeat (32) tick();
        checkOutput("tmo.idle", bus.STATUS, 8'h09);
        checkOutput("tmo.latch_kept", bus.SOUNDLATCH, 8'h11);
        repeat (2) tick();
        checkOutput("tmo.next_latch", bus.SOUNDLATCH, 8'h22);
        checkOutput("tmo.next_status", bus.STATUS, 8'h68);
        cpuWrite(1'b1, 8'h02);
        checkOutput("tmo.cleared", bus.STATUS, 8'h60);
        drainLink();

        // Burst into a full FIFO, overflow, then ordered delivery
        got.delete();
        cpuWrite(1'b0, 8'h01);
        cpuWrite(1'b0, 8'h02);
        cpuWrite(1'b0, 8'h03);
        checkOutput("burst.push_pop", bus.STATUS, 8'h22);
        cpuWrite(1'b0, 8'h04);
        cpuWrite(1'b0, 8'h05);
        checkOutput("burst.full", bus.STATUS, 8'hA4);
        checkOutput("burst.wait", bus.WAIT_68K, 1'b1);
        cpuWrite(1'b0, 8'h06);
        checkOutput("burst.ovf", bus.STATUS, 8'hB4);
        drainLink();
        checkOutput("burst.nbytes", got.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got.size()) checkOutput($sformatf("burst.byte%0d", i), got[i], i + 1);
        end
        checkOutput("burst.ovf_sticky", bus.STATUS, 8'h50);
        cpuWrite(1'b1, 8'h01);
        checkOutput("burst.ovf_clear", bus.STATUS, 8'h40);

        // Flush with a full FIFO keeps the in-flight byte
        cpuWrite(1'b0, 8'hA1);
        cpuWrite(1'b0, 8'hA2);
        cpuWrite(1'b0, 8'hA3);
        cpuWrite(1'b0, 8'hA4);
        cpuWrite(1'b0, 8'hA5);
        checkOutput("flush.full", bus.STATUS, 8'hA4);
        cpuWrite(1'b1, 8'h80);
        checkOutput("flush.status", bus.STATUS, 8'h60);
        checkOutput("flush.wait", bus.WAIT_68K, 1'b0);
        checkOutput("flush.latch", bus.SOUNDLATCH, 8'hA1);
        drainLink();

        // Asynchronous reset in the middle of a pulse
        cpuWrite(1'b0, 8'h3C);
        repeat (4) tick();
        checkOutput("arst.int_before", bus.Z80INT, 1'b1);
        #2;
        RESET96 = 1'b1;
        #1;
        checkOutput("arst.int", bus.Z80INT, 1'b0);
        checkOutput("arst.latch", bus.SOUNDLATCH, 8'h00);
        checkOutput("arst.busy", bus.BUSY, 1'b0);
        repeat (2) tick();
        RESET96 = 1'b0;
        tick();
        checkOutput("arst.status", bus.STATUS, 8'h40);

        // Random traffic against the model
        applyStimulus(1500);
        drainLink();
        checkOutput("rand.final_busy", bus.BUSY, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
